lane_deskew_buffer: RTL
=======================

LANE_DESKEW_BUFFER -- requirements
Module: lane_deskew_buffer

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning number of 32-bit lanes.
REQ-002 SHALL have parameter DEPTH, default 8, meaning per-lane FIFO entries (power of two, >=4).
REQ-003 SHALL have parameter COMMA, default 8'hBC, meaning alignment character expected in byte 0 with its K bit set.
REQ-004 SHALL have port clk  input  1  meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port rst  input  1  meaning the reset, synchronous and active-high.
REQ-006 SHALL have port rdat  input  LANES*32  meaning lane data, lane i at [32i+31:32i].
REQ-007 SHALL have port rdatk  input  LANES*4  meaning K flags, one per byte, lane i at [4i+3:4i].
REQ-008 SHALL have port rdatv  input  LANES  meaning per-lane word valid; no backpressure.
REQ-009 SHALL have port odat  output  LANES*32  meaning deskewed data, same packing as rdat.
REQ-010 SHALL have port odatk  output  LANES*4  meaning deskewed K flags.
REQ-011 SHALL have port ovld  output  1  meaning all lanes present a word and state is LOCKED.
REQ-012 SHALL have port ordy  input  1  meaning consumer accepts the beat when ovld&ordy.
REQ-013 SHALL have port locked  output  1  meaning state is LOCKED.
REQ-014 SHALL have port err_cnt  output  8  meaning saturating count of lock-loss/overflow events.

Function
REQ-015 SHALL keep one FIFO per lane, show-ahead, written when rdatv[i]=1; a word written in cycle N is at the head in cycle N+1.
REQ-016 SHALL define "comma head" for lane i as head byte0 == COMMA and head K bit 0 == 1.
REQ-017 SHALL implement states HUNT and LOCKED; reset state is HUNT.
REQ-018 SHALL, in HUNT, pop lane i every cycle in which lane i is non-empty and its head is not a comma head.
REQ-019 SHALL, in HUNT, hold lane i once its head is a comma head ("found").
REQ-020 SHALL move HUNT->LOCKED on the first cycle in which all lanes are found; locked=1 from the next cycle.
REQ-021 SHALL, in LOCKED, drive ovld=1 iff every lane FIFO is non-empty; odat/odatk are the lane heads.
REQ-022 SHALL pop all lanes together on ovld&ordy; the first beat after lock is the comma beat.
REQ-023 SHALL hold odat/odatk stable while ovld=1 and ordy=0.
REQ-024 SHALL define overflow as rdatv[i]=1 while lane i is full and lane i is not popped in the same cycle; a write to a full FIFO with a simultaneous pop SHALL succeed.
REQ-025 SHALL define misalign as an accepted beat (ovld&ordy) in LOCKED where some but not all lanes have a comma head.
REQ-026 SHALL, on overflow in either state or misalign in LOCKED, flush all FIFOs (empty next cycle), increment err_cnt, and enter or stay in HUNT.
REQ-027 SHALL drop any input word arriving in the same cycle as a flush.
REQ-028 SHALL count at most one error per cycle and saturate err_cnt at 8'hFF.
REQ-029 SHALL keep ovld=0 in HUNT regardless of FIFO contents.
REQ-030 SHALL wrap FIFO read/write pointers modulo DEPTH and track full/empty with one extra pointer bit.

Reset
REQ-031 SHALL, while rst=1 at a clock edge, empty all FIFOs, set state HUNT, locked=0, ovld=0, err_cnt=0; odat/odatk are don't-care while ovld=0.
REQ-032 SHALL discard inputs during reset and resume hunting on the first edge with rst=0; reset mid-LOCKED behaves identically.

Verification
REQ-033 SHALL pass: all 4 lanes send 32'h000000BC K=4'h1 in one cycle, then 32'h1,2,3 -> locked=1 two cycles later; beats {BC},{1},{2},{3} in order with ordy=1.
REQ-034 SHALL pass: lane 2 delayed by 3 cycles relative to lanes 0,1,3, each lane preceded by 32'h55 filler -> fillers discarded, odat lanes equal per beat, err_cnt=0.
REQ-035 SHALL pass: lock, hold ordy=0 while all lanes send DEPTH+1 words -> overflow, FIFOs flushed, locked=0, err_cnt=1.
REQ-036 SHALL pass: lock, then lane 1 alone gets a comma word mid-stream -> misalign at that beat, locked=0, err_cnt=1, re-lock on next all-lane comma.
REQ-037 SHALL pass: force 256 misalign events -> err_cnt reads 8'hFF, no wrap.
REQ-038 SHALL pass: assert rst for 1 cycle while LOCKED with data in FIFOs -> next cycle locked=0, ovld=0, err_cnt=0, all FIFOs empty.

Source files
------------

// File: rtl/lane_deskew_buffer.sv
// Multi-lane deskew buffer: one show-ahead FIFO per lane, hunts for a comma
// on every lane, then releases lane-aligned beats until an error forces a re-hunt.
module lane_deskew_buffer #(
    parameter int         LANES = 4,
    parameter int         DEPTH = 8,
    parameter logic [7:0] COMMA = 8'hBC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [LANES*32-1:0] rdat,
    input  logic [LANES*4-1:0]  rdatk,
    input  logic [LANES-1:0]    rdatv,
    output logic [LANES*32-1:0] odat,
    output logic [LANES*4-1:0]  odatk,
    output logic               ovld,
    input  logic               ordy,
    output logic               locked,
    output logic [7:0]         err_cnt
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {HUNT, LOCKED} state_t;

    state_t          state_reg;
    logic [7:0]      err_cnt_reg;
    logic [LANES-1:0] empty;
    logic [LANES-1:0] full;
    logic [LANES-1:0] comma_head;
    logic [LANES-1:0] found;
    logic [LANES-1:0] pop;
    logic [LANES-1:0] push;
    logic [LANES-1:0] overflow;
    logic            misalign;
    logic            flush;

    assign locked  = (state_reg == LOCKED);
    assign err_cnt = err_cnt_reg;
    assign ovld    = locked && (&(~empty));
    assign found   = ~empty & comma_head;

    // An empty lane's head is stale, so misalign is only judged on a valid beat.
    assign misalign = ovld && ordy && (|comma_head) && !(&comma_head);
    assign overflow = rdatv & full & ~pop;
    assign flush    = (|overflow) || misalign;

    always_comb begin
        pop = '0;
        if (state_reg == LOCKED) begin
            if (ovld && ordy)
                pop = '1;
        end else begin
            pop = ~empty & ~comma_head;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            logic [31:0] mem_d [DEPTH];
            logic [3:0]  mem_k [DEPTH];
            logic [AW:0] wptr_reg;
            logic [AW:0] rptr_reg;

            assign empty[gi] = (wptr_reg == rptr_reg);
            assign full[gi]  = (wptr_reg[AW] != rptr_reg[AW]) &&
                               (wptr_reg[AW-1:0] == rptr_reg[AW-1:0]);

            assign odat[32*gi +: 32] = mem_d[rptr_reg[AW-1:0]];
            assign odatk[4*gi +: 4]  = mem_k[rptr_reg[AW-1:0]];
            assign comma_head[gi]    = (odat[32*gi +: 8] == COMMA) && odatk[4*gi];

            // A full lane still accepts a word when its head leaves this cycle.
            assign push[gi] = rdatv[gi] && !rst && !flush && (!full[gi] || pop[gi]);

            always_ff @(posedge clk) begin
                if (push[gi]) begin
                    mem_d[wptr_reg[AW-1:0]] <= rdat[32*gi +: 32];
                    mem_k[wptr_reg[AW-1:0]] <= rdatk[4*gi +: 4];
                end
            end

            always_ff @(posedge clk) begin
                if (rst || flush) begin
                    wptr_reg <= '0;
                    rptr_reg <= '0;
                end else begin
                    if (push[gi])
                        wptr_reg <= wptr_reg + 1'b1;
                    if (pop[gi])
                        rptr_reg <= rptr_reg + 1'b1;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= HUNT;
            err_cnt_reg <= 8'd0;
        end else if (flush) begin
            state_reg <= HUNT;
            if (err_cnt_reg != 8'hFF)
                err_cnt_reg <= err_cnt_reg + 8'd1;
        end else if (state_reg == HUNT && (&found)) begin
            state_reg <= LOCKED;
        end
    end
endmodule
